// File: rtl/systolic_skew_feeder.sv
// Staging buffer for one DIM x DIM operand matrix, streamed into the MAC array lanes with diagonal skew.
// Define TPU_FEED_TRANSPOSE_EN for column-major (B-side) feed; the default build is row-major.
module systolic_skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       WrEn,
  input  logic [$clog2(DIM)-1:0]     Arow,
  input  logic [DIM*BITS_AB-1:0]     Ain,
  input  logic                       start,
  output logic [DIM*BITS_AB-1:0]     Aout,
  output logic [DIM-1:0]             Avalid,
  output logic                       busy,
  output logic                       done
);

  localparam int T_W = $clog2(2 * DIM);
  localparam logic [T_W-1:0] T_LAST = T_W'(2 * DIM - 1);

  typedef enum logic {
    IDLE,
    FEED
  } state_e;

  state_e                 state_q, state_d;
  logic [T_W-1:0]         t_q, t_d;
  logic [DIM*BITS_AB-1:0] aout_q, aout_d;
  logic [DIM-1:0]         avalid_q, avalid_d;
  logic                   done_q, done_d;
  logic [BITS_AB-1:0]     mem_q [DIM][DIM];
  logic [BITS_AB-1:0]     mem_d [DIM][DIM];

  logic [T_W-1:0]         t_sel;
  logic [DIM*BITS_AB-1:0] slot_data;
  logic [DIM-1:0]         slot_valid;

  // Lane i carries the element whose index pair sums to the slot number, so
  // each lane sees its vector exactly i slots after lane 0.
  always_comb begin
    t_sel      = (state_q == FEED) ? t_q : '0;
    slot_data  = '0;
    slot_valid = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int c = 0; c < DIM; c++) begin
        if (t_sel == T_W'(i + c)) begin
`ifdef TPU_FEED_TRANSPOSE_EN
          slot_data[i*BITS_AB +: BITS_AB] = mem_q[c][i];
`else
          slot_data[i*BITS_AB +: BITS_AB] = mem_q[i][c];
`endif
          slot_valid[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    aout_d   = aout_q;
    avalid_d = avalid_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    case (state_q)
      IDLE: begin
        aout_d   = '0;
        avalid_d = '0;
        if (WrEn) begin
          for (int j = 0; j < DIM; j++) begin
            mem_d[Arow][j] = Ain[j*BITS_AB +: BITS_AB];
          end
        end else if (start && en) begin
          state_d  = FEED;
          aout_d   = slot_data;
          avalid_d = slot_valid;
          t_d      = T_W'(1);
        end
      end
      FEED: begin
        if (en) begin
          if (t_q == T_LAST) begin
            aout_d   = '0;
            avalid_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
            t_d      = '0;
          end else begin
            aout_d   = slot_data;
            avalid_d = slot_valid;
            t_d      = t_q + T_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= '0;
      aout_q   <= '0;
      avalid_q <= '0;
      done_q   <= 1'b0;
      // NOTE: the matrix storage is reset on purpose; a feed after reset must stream zeros, not stale operands.
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      aout_q   <= aout_d;
      avalid_q <= avalid_d;
      done_q   <= done_d;
      mem_q    <= mem_d;
    end
  end

  assign Aout   = aout_q;
  assign Avalid = avalid_q;
  assign busy   = (state_q == FEED);
  assign done   = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder at DIM=4, BITS_AB=8: skew, signed data, stall, collisions, reset.
module tb_systolic_skew_feeder;

  localparam int BITS_AB = 8;
  localparam int DIM     = 4;
  localparam int W       = DIM * BITS_AB;
  localparam int SLOTS   = 2 * DIM - 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           en    = 1'b0;
  logic           wr_en = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     arow  = '0;
  logic [W-1:0]   ain   = '0;
  logic [W-1:0]   aout;
  logic [DIM-1:0] avalid;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  logic [7:0]     mdl   [DIM][DIM];
  logic [W-1:0]   cap_a [SLOTS];
  logic [DIM-1:0] cap_v [SLOTS];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .WrEn   (wr_en),
    .Arow   (arow),
    .Ain    (ain),
    .start  (start),
    .Aout   (aout),
    .Avalid (avalid),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_aout(input int t);
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIM; i++) begin
      if (t - i >= 0 && t - i < DIM) begin
`ifdef TPU_FEED_TRANSPOSE_EN
        v[i*BITS_AB +: BITS_AB] = mdl[t-i][i];
`else
        v[i*BITS_AB +: BITS_AB] = mdl[i][t-i];
`endif
      end
    end
    return v;
  endfunction

  function automatic logic [DIM-1:0] exp_valid(input int t);
    logic [DIM-1:0] v = '0;
    for (int i = 0; i < DIM; i++) begin
      if (t - i >= 0 && t - i < DIM) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " aout"}, aout, '0);
    check({tag, " valid/busy/done"}, W'({avalid, busy, done}), '0);
  endtask

  task automatic write_row(input int r, input logic [W-1:0] data);
    wr_en = 1'b1;
    arow  = 2'(r);
    ain   = data;
    tick();
    wr_en = 1'b0;
    for (int j = 0; j < DIM; j++) mdl[r][j] = data[j*BITS_AB +: BITS_AB];
  endtask

  // One complete feed; optional stall, write strobe and stray start at given slots.
  task automatic run_feed(input int stall_at, input int stall_len, input int wr_at, input int start_at);
    en    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      cap_a[k] = aout;
      cap_v[k] = avalid;
      check($sformatf("aout t%0d", k), aout, exp_aout(k));
      check($sformatf("avalid t%0d", k), W'(avalid), W'(exp_valid(k)));
      check($sformatf("busy t%0d", k), W'(busy), W'(1));
      check($sformatf("done t%0d", k), W'(done), '0);
      if (k == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check($sformatf("stall aout s%0d", s), aout, exp_aout(k));
          check($sformatf("stall valid/busy/done s%0d", s), W'({avalid, busy, done}),
                W'({exp_valid(k), 1'b1, 1'b0}));
        end
        en = 1'b1;
      end
      wr_en = (k == wr_at);
      start = (k == start_at);
      if (k == wr_at) begin
        arow = 2'd1;
        ain  = '1;
      end
      tick();
    end
    wr_en = 1'b0;
    start = 1'b0;
    check("done pulse", W'(done), W'(1));
    check("aout at done", aout, '0);
    check("valid/busy at done", W'({avalid, busy}), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] row;
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) mdl[r][c] = '0;

    // Asynchronous reset, asserted between clock edges.
    #2 rst_n = 1'b0;
    #1 check_idle("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("idle c%0d", i));
    end

    // Basic skew with A[r][c] = 16r + c.
    for (int r = 0; r < DIM; r++) begin
      for (int j = 0; j < DIM; j++) row[j*BITS_AB +: BITS_AB] = 8'(16 * r + j);
      write_row(r, row);
    end
    run_feed(-1, 0, -1, -1);
    check("edge0 aout", cap_a[0], 32'h0000_0000);
    check("edge0 valid", W'(cap_v[0]), W'(4'b0001));
`ifdef TPU_FEED_TRANSPOSE_EN
    check("edge3 aout", cap_a[3], 32'h0312_2130);
`else
    check("edge3 aout", cap_a[3], 32'h3021_1203);
`endif
    check("edge3 valid", W'(cap_v[3]), W'(4'b1111));
    check("edge6 aout", cap_a[6], 32'h3300_0000);
    check("edge6 valid", W'(cap_v[6]), W'(4'b1000));
    tick();
    check_idle("after done");

    // Stall of three cycles at t=2.
    run_feed(2, 3, -1, -1);
    tick();

    // Signed extremes pass through unchanged.
    write_row(0, 32'h0302_7F80);
    run_feed(-1, 0, -1, -1);
    check("signed -128", W'(cap_a[0][7:0]), W'(8'h80));
`ifdef TPU_FEED_TRANSPOSE_EN
    check("signed 127", W'(cap_a[1][15:8]), W'(8'h7F));
`else
    check("signed 127", W'(cap_a[1][7:0]), W'(8'h7F));
`endif
    tick();

    // Write strobe and stray start during FEED; the next feed proves storage is intact.
    run_feed(-1, 0, 2, 4);
    tick();
    check_idle("stray start ignored");
    run_feed(-1, 0, -1, -1);
    tick();

    // start together with WrEn in IDLE: only the write happens.
    wr_en = 1'b1;
    start = 1'b1;
    arow  = 2'd2;
    ain   = 32'hA5C3_5A7E;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    for (int j = 0; j < DIM; j++) mdl[2][j] = ain[j*BITS_AB +: BITS_AB];
    check("start+wr busy", W'(busy), '0);
    tick();
    check_idle("start+wr idle");

    // Back-to-back feeds; the second start lands in the done cycle.
    run_feed(-1, 0, -1, -1);
    run_feed(-1, 0, -1, -1);
    tick();

    // Reset in the middle of a feed.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre-reset aout", aout, exp_aout(3));
    #2 rst_n = 1'b0;
    #1 check_idle("mid-feed reset");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("post-reset c%0d", i));
    end
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) mdl[r][c] = '0;
    run_feed(-1, 0, -1, -1);
    check("zero feed aout", cap_a[3], '0);
    check("zero feed valid", W'(cap_v[3]), W'(4'b1111));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
